// File: rtl/uart_pkg.sv
// Shared constants, state encodings and elaboration-time helpers for the UART frame receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Widest character the receiver supports; narrower characters are zero-extended.
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    F_EMPTY = 2'd0,
    F_FILL  = 2'd1,
    F_HOLD  = 2'd2
  } frame_state_t;

  // Clocks per oversample tick, truncated, never below one.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned d;
    d = clk_hz / (baud * oversample);
    return (d == 0) ? 1 : d;
  endfunction

  // Ticks of continuous line idle that close an open frame.
  function automatic int unsigned calc_idle_ticks(input int unsigned idle_chars,
                                                  input int unsigned data_bits,
                                                  input int unsigned parity,
                                                  input int unsigned oversample);
    int unsigned bits;
    bits = 2 + data_bits + ((parity != PAR_NONE) ? 1 : 0);
    return idle_chars * bits * oversample;
  endfunction

  // Counter width able to hold 0..v-1, at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  // True when the received parity bit disagrees with the configured parity.
  function automatic logic parity_bad(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     par_bit,
                                      input int unsigned              parity);
    logic ones_odd;
    ones_odd = (^data) ^ par_bit;
    if (parity == PAR_ODD)  return ~ones_odd;
    if (parity == PAR_EVEN) return ones_odd;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Serial front end: line synchroniser, oversample tick divider and per-bit receive FSM.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_async,
  output logic                 tick_c,
  output logic                 rx_idle_c,
  output logic                 char_valid_c,
  output logic                 frame_err_c,
  output logic                 parity_err_c,
  output logic [DATA_BITS-1:0] char_data
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = clog2_min1(DIV);
  localparam int unsigned OS_W  = clog2_min1(OVERSAMPLE);
  localparam int unsigned HALF  = OVERSAMPLE / 2;
  localparam int unsigned IDX_W = 4;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  rx_state_t            state;
  logic [OS_W-1:0]      tcnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 sample_mid;
  logic                 sample_full;
  logic                 stop_tick;
  logic                 par_err;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_async};
    end
  end

  // Free-running divider producing one tick every DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_c      = (div_cnt == DIV_W'(DIV - 1));
  assign sample_mid  = tick_c && (tcnt == OS_W'(HALF - 1));
  assign sample_full = tick_c && (tcnt == OS_W'(OVERSAMPLE - 1));

  // Bit FSM: start qualification at mid-bit, then one sample per bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            tcnt  <= '0;
          end
        end
        RX_START: begin
          if (sample_mid) begin
            tcnt    <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else if (tick_c) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (sample_full) begin
            tcnt  <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state <= (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else if (tick_c) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RX_PAR: begin
          if (sample_full) begin
            tcnt  <= '0;
            par_q <= rx_s;
            state <= RX_STOP;
          end else if (tick_c) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (sample_full) begin
            tcnt  <= '0;
            state <= RX_IDLE;
          end else if (tick_c) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state <= RX_IDLE;
          tcnt  <= '0;
        end
      endcase
    end
  end

  // Stop-bit verdict; a low stop bit takes precedence over a parity mismatch.
  assign stop_tick    = (state == RX_STOP) && sample_full;
  assign par_err      = parity_bad(MAX_DATA_BITS'(shreg), par_q, PARITY);
  assign frame_err_c  = stop_tick && !rx_s;
  assign parity_err_c = stop_tick && rx_s && par_err;
  assign char_valid_c = stop_tick && rx_s && !par_err;
  assign rx_idle_c    = (state == RX_IDLE);
  assign char_data    = shreg;

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: buffers accepted characters into block memory and hands off whole frames.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned IDLE_CHARS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_uart_rx,
  input  logic                 i_release,
  output logic                 o_mem_en,
  output logic                 o_mem_wen,
  output logic [ADDR_W-1:0]    o_mem_waddr,
  output logic [DATA_BITS-1:0] o_mem_wdata,
  output logic                 o_mem_wdone,
  output logic [ADDR_W:0]      o_mem_byte,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overflow
);

  localparam int unsigned IDLE_TICKS = calc_idle_ticks(IDLE_CHARS, DATA_BITS, PARITY, OVERSAMPLE);
  localparam int unsigned TMR_W      = clog2_min1(IDLE_TICKS + 1);
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic                 tick_c;
  logic                 rx_idle_c;
  logic                 char_valid_c;
  logic                 frame_err_c;
  logic                 parity_err_c;
  logic [DATA_BITS-1:0] char_data;

  frame_state_t         fstate;
  logic [ADDR_W:0]      wr_cnt;
  logic [TMR_W-1:0]     idle_tmr;
  logic                 last_slot;
  logic                 idle_expired;

  uart_rx_core #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY)
  ) u_core (
    .clk          (i_clk),
    .rst_n        (i_reset),
    .rx_async     (i_uart_rx),
    .tick_c       (tick_c),
    .rx_idle_c    (rx_idle_c),
    .char_valid_c (char_valid_c),
    .frame_err_c  (frame_err_c),
    .parity_err_c (parity_err_c),
    .char_data    (char_data)
  );

  assign last_slot    = (wr_cnt == (ADDR_W + 1)'(DEPTH - 1));
  assign idle_expired = (idle_tmr == TMR_W'(IDLE_TICKS));

  // Idle timer: restarts on every character verdict, advances on ticks while an open frame sees a quiet line.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      idle_tmr <= '0;
    end else if (char_valid_c || frame_err_c || parity_err_c) begin
      idle_tmr <= '0;
    end else if (fstate == F_HOLD && i_release) begin
      idle_tmr <= '0;
    end else if (fstate == F_FILL && rx_idle_c && tick_c && !idle_expired) begin
      idle_tmr <= idle_tmr + 1'b1;
    end
  end

  // Frame FSM with registered memory port, completion, count and status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fstate       <= F_EMPTY;
      wr_cnt       <= '0;
      o_mem_en     <= 1'b0;
      o_mem_wen    <= 1'b0;
      o_mem_waddr  <= '0;
      o_mem_wdata  <= '0;
      o_mem_wdone  <= 1'b0;
      o_mem_byte   <= '0;
      o_busy       <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_mem_en     <= 1'b0;
      o_mem_wen    <= 1'b0;
      o_mem_wdone  <= 1'b0;
      o_overflow   <= 1'b0;
      o_frame_err  <= frame_err_c;
      o_parity_err <= parity_err_c;
      case (fstate)
        F_EMPTY, F_FILL: begin
          if (char_valid_c) begin
            o_mem_en    <= 1'b1;
            o_mem_wen   <= 1'b1;
            o_mem_waddr <= wr_cnt[ADDR_W-1:0];
            o_mem_wdata <= char_data;
            wr_cnt      <= wr_cnt + 1'b1;
            o_busy      <= 1'b1;
            if (last_slot) begin
              // Buffer full: the final write also closes the frame.
              o_mem_wdone <= 1'b1;
              o_mem_byte  <= wr_cnt + 1'b1;
              fstate      <= F_HOLD;
            end else begin
              fstate <= F_FILL;
            end
          end else if (fstate == F_FILL && idle_expired) begin
            o_mem_wdone <= 1'b1;
            o_mem_byte  <= wr_cnt;
            fstate      <= F_HOLD;
          end
        end
        F_HOLD: begin
          // Held frame is untouchable; a concurrent character is dropped even when released.
          if (char_valid_c) begin
            o_overflow <= 1'b1;
          end
          if (i_release) begin
            fstate     <= F_EMPTY;
            wr_cnt     <= '0;
            o_mem_byte <= '0;
            o_busy     <= 1'b0;
          end
        end
        default: begin
          fstate <= F_EMPTY;
          wr_cnt <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomised scoreboard bench for uart_frame_rx (8E1, DIV=4, 16x oversample, 8-entry buffer).
module tb_uart_frame_rx;

  localparam int unsigned OS        = 16;
  localparam int unsigned DIVR      = 4;
  localparam int unsigned BAUD_R    = 115200;
  localparam int unsigned CLK_R     = BAUD_R * OS * DIVR;
  localparam int unsigned DB        = 8;
  localparam int unsigned PAR       = 2;
  localparam int unsigned AW        = 3;
  localparam int unsigned IDLE_C    = 2;
  localparam int unsigned DEPTH     = 1 << AW;
  localparam int unsigned BIT       = OS * DIVR;
  localparam int unsigned IDLE_CLKS = IDLE_C * (2 + DB + 1) * BIT;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic          rel;
  logic          o_mem_en;
  logic          o_mem_wen;
  logic [AW-1:0] o_mem_waddr;
  logic [DB-1:0] o_mem_wdata;
  logic          o_mem_wdone;
  logic [AW:0]   o_mem_byte;
  logic          o_busy;
  logic          o_frame_err;
  logic          o_parity_err;
  logic          o_overflow;

  uart_frame_rx #(
    .CLK_HZ     (CLK_R),
    .BAUD       (BAUD_R),
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .PARITY     (PAR),
    .ADDR_W     (AW),
    .IDLE_CHARS (IDLE_C)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_uart_rx    (rx),
    .i_release    (rel),
    .o_mem_en     (o_mem_en),
    .o_mem_wen    (o_mem_wen),
    .o_mem_waddr  (o_mem_waddr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wdone  (o_mem_wdone),
    .o_mem_byte   (o_mem_byte),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_WRITE, EV_DONE, EV_FERR, EV_PERR, EV_OVF} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned addr;
    int unsigned data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference frame model: characters in the open/held frame and whether it is held.
  int  frame_cnt = 0;
  bit  held = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input int unsigned a, input int unsigned d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d, required no event at %0t", int'(k), $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      if (k == e.kind && k == EV_WRITE) begin
        check("write_addr", int'(o_mem_waddr), e.addr);
        check("write_data", int'(o_mem_wdata), e.data);
      end
      if (k == e.kind && k == EV_DONE) begin
        check("done_byte_count", int'(o_mem_byte), e.data);
      end
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_mem_en || o_mem_wen) check("mem_en_eq_wen", int'(o_mem_en), int'(o_mem_wen));
      if (o_mem_wen)    pop_check(EV_WRITE);
      if (o_mem_wdone)  pop_check(EV_DONE);
      if (o_frame_err)  pop_check(EV_FERR);
      if (o_parity_err) pop_check(EV_PERR);
      if (o_overflow)   pop_check(EV_OVF);
    end
  end

  task automatic line_hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 good, 1 low stop bit, 2 wrong parity bit.
  task automatic send_char(input logic [7:0] d, input int kind, input int unsigned gap);
    logic        par;
    int unsigned g;
    if (kind == 1) push_ev(EV_FERR, 0, 0);
    else if (kind == 2) push_ev(EV_PERR, 0, 0);
    else if (held) push_ev(EV_OVF, 0, 0);
    else begin
      push_ev(EV_WRITE, frame_cnt, d);
      frame_cnt++;
      if (frame_cnt == DEPTH) begin
        push_ev(EV_DONE, 0, frame_cnt);
        held = 1'b1;
      end
    end
    par = (^d) ^ (kind == 2);
    line_hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) line_hold(d[i], BIT);
    line_hold(par, BIT);
    if (kind == 1) begin
      line_hold(1'b0, (BIT * 3) / 4);
      line_hold(1'b1, BIT / 4);
    end else begin
      line_hold(1'b1, BIT);
    end
    g = (kind == 1 && gap < 1) ? 1 : gap;
    line_hold(1'b1, g * BIT);
  endtask

  task automatic idle_long();
    if (frame_cnt > 0 && !held) begin
      push_ev(EV_DONE, 0, frame_cnt);
      held = 1'b1;
    end
    line_hold(1'b1, IDLE_CLKS + 160);
    check("busy_after_idle", int'(o_busy), (frame_cnt > 0) ? 1 : 0);
    check("byte_after_idle", int'(o_mem_byte), held ? frame_cnt : 0);
  endtask

  task automatic do_release();
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    if (held) begin
      held = 1'b0;
      frame_cnt = 0;
    end
    @(negedge clk);
    check("busy_after_release", int'(o_busy), (frame_cnt > 0) ? 1 : 0);
    check("byte_after_release", int'(o_mem_byte), held ? frame_cnt : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, int'(o_mem_en), 0);
    check({tag, "_mem_wen"}, int'(o_mem_wen), 0);
    check({tag, "_waddr"}, int'(o_mem_waddr), 0);
    check({tag, "_wdata"}, int'(o_mem_wdata), 0);
    check({tag, "_wdone"}, int'(o_mem_wdone), 0);
    check({tag, "_byte"}, int'(o_mem_byte), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_ferr"}, int'(o_frame_err), 0);
    check({tag, "_perr"}, int'(o_parity_err), 0);
    check({tag, "_ovf"}, int'(o_overflow), 0);
  endtask

  // Watchdog keeps the run bounded if the DUT or bench stalls.
  initial begin
    repeat (95000) @(posedge clk);
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [7:0] v;
    int         k;
    rst_n = 1'b0;
    rx    = 1'b1;
    rel   = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    line_hold(1'b1, 2 * BIT);

    // Back-to-back frame closed by idle.
    send_char(8'h55, 0, 0);
    send_char(8'hA3, 0, 0);
    send_char(8'h0F, 0, 0);
    idle_long();
    do_release();

    // Short start glitch is ignored.
    line_hold(1'b0, 3 * DIVR);
    line_hold(1'b1, 2 * BIT);
    check("busy_after_glitch", int'(o_busy), 0);

    // Framing error, then a good character lands at address 0.
    send_char(8'h41, 1, 1);
    send_char(8'h42, 0, 0);
    idle_long();
    do_release();

    // Parity error, then the same byte with correct parity.
    send_char(8'h07, 2, 0);
    send_char(8'h07, 0, 0);
    idle_long();
    do_release();

    // Fill the buffer: eighth write closes, ninth overflows; release reopens at 0.
    for (int i = 0; i < 9; i++) send_char(8'($urandom_range(0, 255)), 0, 0);
    idle_long();
    do_release();
    send_char(8'hC9, 0, 0);
    do_release();
    idle_long();
    do_release();

    // Randomised traffic with errors, gaps, idle closes and stray releases.
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 9));
      k = (k == 0) ? 1 : (k == 1) ? 2 : 0;
      v = 8'($urandom_range(0, 255));
      send_char(v, k, $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0 && !held) do_release();
      if ($urandom_range(0, 6) == 0) begin
        idle_long();
        if ($urandom_range(0, 2) != 0) do_release();
      end
      if ($urandom_range(0, 9) == 0) line_hold(1'b0, 2 * DIVR + $urandom_range(0, 12));
      line_hold(1'b1, BIT);
    end
    idle_long();
    do_release();

    // Reset in the middle of a data bit of 0x3C while a frame is held.
    send_char(8'h11, 0, 0);
    idle_long();
    check("queue_before_reset", exp_q.size(), 0);
    v = 8'h3C;
    line_hold(1'b0, BIT);
    line_hold(v[0], BIT);
    line_hold(v[1], BIT);
    line_hold(v[2], BIT / 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midchar_reset");
    rx = 1'b1;
    frame_cnt = 0;
    held = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    line_hold(1'b1, 2 * BIT);
    send_char(8'h3C, 0, 0);
    idle_long();
    do_release();

    line_hold(1'b1, 2 * BIT);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Parametrised UART frame receiver; successor to the fixed 8N1 receive path. Deserialises the line, writes each accepted character into an external simple-dual-port block memory and closes a frame on line idle or buffer full. A completed frame is held with a done pulse and byte count until the consumer (transmit/loopback block or PS bridge) releases it. Adds over the fixed path: configurable baud, oversampling, data width and parity; glitch rejection; framing/parity error reporting; and overflow protection.

## Interface
- CLK_HZ, 125000000, input clock frequency
- BAUD, 115200, line rate
- OVERSAMPLE, 16, ticks per bit (even, >=4)
- DATA_BITS, 8, character width (5..9)
- PARITY, 0, 0 none / 1 odd / 2 even
- ADDR_W, 10, memory address width (depth 2^ADDR_W)
- IDLE_CHARS, 2, idle character-times that close a frame
- i_clk  in  1  single clock; all logic in this domain
- i_reset  in  1  asynchronous, active-low reset
- i_uart_rx  in  1  serial line, idle high, asynchronous
- i_release  in  1  one-cycle pulse; consumer finished reading the held frame
- o_mem_en  out  1  memory port-A enable (equal to o_mem_wen)
- o_mem_wen  out  1  one-cycle write strobe
- o_mem_waddr  out  ADDR_W  write address
- o_mem_wdata  out  DATA_BITS  character, LSB first on the line
- o_mem_wdone  out  1  one-cycle frame-complete pulse
- o_mem_byte  out  ADDR_W+1  byte count of held frame
- o_busy  out  1  frame open or held
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_parity_err  out  1  one-cycle pulse: parity mismatch
- o_overflow  out  1  one-cycle pulse: character dropped while frame held

## Operation
- Tick divider: DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated, minimum 1; one-cycle tick every DIV clocks.
- i_uart_rx passes through a 2-FF synchroniser, reset to 1.
- Bit FSM RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP:
  - RX_IDLE: low level -> RX_START, tick counter cleared.
  - RX_START: at OVERSAMPLE/2 ticks, still low -> RX_DATA; high -> RX_IDLE (glitch, nothing reported).
  - RX_DATA: samples every OVERSAMPLE ticks, LSB first. After DATA_BITS samples -> RX_PAR if PARITY!=0, else RX_STOP.
  - RX_STOP: a low sample pulses o_frame_err and discards the character. A parity mismatch pulses o_parity_err and discards. Otherwise the character is accepted. All cases -> RX_IDLE.
- Frame FSM F_EMPTY, F_FILL, F_HOLD:
  - F_EMPTY/F_FILL, accepted character: written at the current address, address +1, -> F_FILL.
  - Idle timer clears on each accepted or errored character. It counts ticks in F_FILL while the bit FSM is in RX_IDLE.
  - Timer reaches IDLE_CHARS*(2+DATA_BITS+(PARITY!=0))*OVERSAMPLE: latch count into o_mem_byte, pulse o_mem_wdone, -> F_HOLD.
  - Write filling 2^ADDR_W entries: close the frame immediately, same actions, -> F_HOLD.
  - F_HOLD: accepted characters are not written and pulse o_overflow. i_release -> F_EMPTY, address 0, o_mem_byte 0.
  - i_release outside F_HOLD is ignored.
- Release and character acceptance in the same cycle in F_HOLD: the character is dropped with o_overflow, and the release takes effect.

## Timing
- Reset: all outputs 0. Both FSMs idle/empty; address 0; synchroniser 1.
- Reset is effective immediately, including mid-character.
- Write: o_mem_en/o_mem_wen/o_mem_waddr/o_mem_wdata registered. Valid exactly one cycle, the cycle after the stop-bit sample tick.
- Error and overflow pulses occur in the same cycle a write would have occurred.
- Full close: o_mem_wdone coincides with the last write strobe.
- Idle close: o_mem_wdone occurs one cycle after the timer threshold.
- o_mem_byte is valid from the o_mem_wdone cycle and stable until the cycle after i_release.
- o_busy = F_FILL or F_HOLD, registered.

## Structure
- Package uart_pkg:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - bit and frame state encodings
  - divisor and idle-threshold constant functions
- Sub-module uart_rx_core: synchroniser, tick divider and bit FSM. Outputs a character-valid pulse, data, and error pulses.
- Frame FSM, address/count logic and memory port stay in uart_frame_rx.

## Test plan
- DIV=4, 8N1; send 0x55, 0xA3, 0x0F back to back, then idle -> writes at addr 0/1/2 with those data; single o_mem_wdone; o_mem_byte=3.
- Line low for 3 ticks with OVERSAMPLE=16 -> no write, no error, FSM back in RX_IDLE.
- 0x41 with stop bit low -> o_frame_err pulse, no write, next good byte written at addr 0.
- PARITY=2; 0x07 with parity bit 0 -> o_parity_err, no write. Same byte with parity bit 1 -> written.
- ADDR_W=3; send 9 bytes -> 8 writes, o_mem_wdone with 8th write, o_mem_byte=8; 9th byte -> o_overflow. After i_release, next byte written at addr 0.
- Reset asserted mid-data-bit of 0x3C -> outputs 0 at once. After deassert, clean 0x3C written at addr 0.
